router_1xn_core: RTL

//  Parametrised 1xN packet router: next generation of the 1x3 router.

---
 rtl/router_pkg.sv | 20 ++
 rtl/router_1xn_core_if.sv | 19 +
 rtl/router_chan_fifo.sv | 81 ++++++++
 rtl/router_1xn_core.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared state encoding, default sizing and header field helpers for the 1xN router.
// Header layout is {len, addr} with addr in the low ADDR_W bits.
package router_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_TIMEOUT    = 30;

  typedef enum logic [2:0] {IDLE, WAIT_EMPTY, LOAD, CHECK, DROP} state_t;

  function automatic logic [31:0] hdr_addr(input logic [31:0] hdr, input int unsigned addr_w);
    return hdr & ((32'd1 << addr_w) - 32'd1);
  endfunction

  function automatic logic [31:0] hdr_len(input logic [31:0] hdr, input int unsigned addr_w);
    return hdr >> addr_w;
  endfunction

endpackage

// File: rtl/router_1xn_core_if.sv
// Source-side byte stream plus NUM_CH read-side channels of the 1xN router.
// Source must hold data_in/pkt_valid while busy is high.
interface router_1xn_core_if
  import router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH
);
  logic [DATA_W-1:0]        data_in;
  logic                     pkt_valid;
  logic                     busy;
  logic                     error;
  logic [NUM_CH-1:0]        read_enb;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic [NUM_CH-1:0]        vld_out;

  modport master (output data_in, pkt_valid, read_enb, input busy, error, data_out, vld_out);
  modport slave  (input data_in, pkt_valid, read_enb, output busy, error, data_out, vld_out);
endinterface

// File: rtl/router_chan_fifo.sv
// Per-channel FIFO: write visible as not-empty next cycle, registered read data one edge after rd_en.
// Full blocks writes regardless of a same-cycle read; TIMEOUT idle cycles with data pending flush it.
module router_chan_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_dat,
  output logic              empty,
  output logic              full,
  output logic              flush
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              wr_ok, rd_ok;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign flush  = (tmr_q == TMR_W'(TIMEOUT));
  assign wr_ok  = wr_en && !full && !flush;
  assign rd_ok  = rd_en && !empty && !flush;
  assign rd_dat = dout_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    dout_d   = dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      tmr_d    = '0;
      dout_d   = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        dout_d   = mem_q[rd_ptr_q];
      end
      cnt_d = cnt_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
      // Idle timer only runs while data is waiting and nobody reads it.
      if (rd_ok || empty) tmr_d = '0;
      else                tmr_d = tmr_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/router_1xn_core.sv
// 1xN packet router: header-addressed demux into NUM_CH FIFOs with parity check, 1-cycle write latency.
// busy stalls the source while the target FIFO is full, draining before a new header, or checking parity.
module router_1xn_core
  import router_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input logic             clk,
  input logic             reset,
  router_1xn_core_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_CH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, in_addr, cur_addr;
  logic [DATA_W-1:0]   hdr_q, hdr_d, par_q, par_d, pbyte_q, pbyte_d, wr_dat;
  logic                err_q, err_d, quiet_q, quiet_d;
  logic                in_valid, wr, busy;
  logic                tgt_full, tgt_empty, tgt_flush;
  logic [NUM_CH-1:0]   wr_en, full, empty, flush;
  logic [NUM_CH*DATA_W-1:0] dout_flat;

  assign in_addr  = ADDR_W'(hdr_addr(32'(bus.data_in), ADDR_W));
  assign in_valid = hdr_addr(32'(bus.data_in), ADDR_W) < 32'(NUM_CH);
  // In IDLE the incoming header selects the target; afterwards the latched address does.
  assign cur_addr = (state_q == IDLE) ? in_addr : addr_q;

  always_comb begin
    tgt_full  = 1'b0;
    tgt_empty = 1'b0;
    tgt_flush = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cur_addr == ADDR_W'(i)) begin
        tgt_full  = full[i];
        tgt_empty = empty[i];
        tgt_flush = flush[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hdr_d   = hdr_q;
    par_d   = par_q;
    pbyte_d = pbyte_q;
    err_d   = err_q;
    quiet_d = quiet_q;
    wr      = 1'b0;
    wr_dat  = bus.data_in;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pkt_valid) begin
          hdr_d   = bus.data_in;
          addr_d  = in_addr;
          par_d   = bus.data_in;
          err_d   = 1'b0;
          quiet_d = 1'b0;
          if (!in_valid)      state_d = DROP;
          else if (tgt_empty) begin
            wr      = 1'b1;
            state_d = LOAD;
          end else            state_d = WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: begin
        busy = 1'b1;
        if (tgt_empty) begin
          wr      = 1'b1;
          wr_dat  = hdr_q;
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy = tgt_full;
        // A flushed target abandons the rest of the packet without flagging an error.
        if (tgt_flush) begin
          if (!tgt_full && !bus.pkt_valid) state_d = IDLE;
          else begin
            quiet_d = 1'b1;
            state_d = DROP;
          end
        end else if (!tgt_full) begin
          wr = 1'b1;
          if (bus.pkt_valid) par_d = par_q ^ bus.data_in;
          else begin
            pbyte_d = bus.data_in;
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        busy    = 1'b1;
        err_d   = (par_q != pbyte_q);
        state_d = IDLE;
      end
      DROP: begin
        if (!bus.pkt_valid) begin
          err_d   = !quiet_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < NUM_CH; i++) wr_en[i] = wr && (cur_addr == ADDR_W'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      hdr_q   <= '0;
      par_q   <= '0;
      pbyte_q <= '0;
      err_q   <= 1'b0;
      quiet_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hdr_q   <= hdr_d;
      par_q   <= par_d;
      pbyte_q <= pbyte_d;
      err_q   <= err_d;
      quiet_q <= quiet_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    router_chan_fifo #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH),
      .TIMEOUT   (TIMEOUT)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_en[g]),
      .wr_dat(wr_dat),
      .rd_en (bus.read_enb[g]),
      .rd_dat(dout_flat[g*DATA_W +: DATA_W]),
      .empty (empty[g]),
      .full  (full[g]),
      .flush (flush[g])
    );
  end

  assign bus.busy     = busy;
  assign bus.error    = err_q;
  assign bus.vld_out  = ~empty;
  assign bus.data_out = dout_flat;

endmodule
